ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Memory-side responder for the CPU RAM bus: bus_RAM_ADDRESS, wire_RW, bus_RAM_DATA_IN and bus_RAM_DATA_OUT.
- Holds a single-port, word-addressed 16-bit array.
- After reset it clears the array while holding ready low, then serves one read or write per clock.
- Read data returns after a fixed, parameterised latency. The CPU's load and store instruction sequences count on that latency.

Parameters:
- DEPTH, 4096, number of 16-bit words; legal addresses are 0..DEPTH-1.
- READ_LATENCY, 1, clock edges from address sample to valid read data; legal range 1..3.
- INIT_VALUE, 16'h0000, word written to every location during init.
- PROTECT_TOP, 16'h0100, addresses below this are read-only; used only with the optional feature.

Ports:
- wire_clock  in  1  system clock; all state changes on the rising edge.
- wire_reset  in  1  asynchronous reset, active-high.
- bus_RAM_ADDRESS  in  16  word address driven by the CPU.
- wire_RW  in  1  1 = write, 0 = read (CPU idles at 0).
- bus_RAM_DATA_IN  in  16  write data from the CPU.
- bus_RAM_DATA_OUT  out  16  read data to the CPU.
- wire_RAM_READY  out  1  high once init is complete and requests are being served.
- wire_RAM_ERROR  out  1  one-cycle pulse on an out-of-range or protected access.

Behaviour:
- Reset values (while wire_reset is high):
  - bus_RAM_DATA_OUT = 0, wire_RAM_READY = 0, wire_RAM_ERROR = 0.
  - State = ST_INIT, init counter = 0, read pipeline valid bits = 0.
- FSM, ST_INIT:
  - Each edge writes INIT_VALUE to array[init counter], then increments the counter.
  - On the edge that writes DEPTH-1, go to ST_SERVE; wire_RAM_READY rises on that same edge.
  - Init therefore takes exactly DEPTH cycles.
  - All bus inputs are ignored and bus_RAM_DATA_OUT stays 0.
- FSM, ST_SERVE:
  - Every edge samples address, wire_RW and data_in.
  - Exactly one access per edge; there is no idle encoding, so a read with RW=0 occurs every cycle.
- Write (RW=1, address < DEPTH): array[address] = data_in on the sampling edge.
- Read (RW=0, address < DEPTH):
  - array[address] enters the read pipeline on the sampling edge.
  - The value appears on bus_RAM_DATA_OUT READ_LATENCY edges later: sampled at edge N, visible after edge N+READ_LATENCY.
- Write at edge N followed by a read of the same address at N+1: returns the new data.
- During a write, the write enters the pipeline as a bubble. bus_RAM_DATA_OUT holds its previous value when a bubble reaches the output.
- Out-of-range access (address >= DEPTH):
  - A write is discarded.
  - A read pushes 16'h0000 through the pipeline, and that zero is driven at the output.
  - wire_RAM_ERROR pulses high for one cycle, READ_LATENCY edges after the sample, aligned with the data.
- Consecutive accesses are fully pipelined. The throughput is one per cycle for any READ_LATENCY.
- Reset asserted mid-operation:
  - Immediately aborts in-flight reads: pipeline flushed, output 0.
  - On release, re-enters ST_INIT and clears the whole array again.
- Address 16'hFFFF with DEPTH = 65536 is legal; the init counter stops after DEPTH-1 and does not wrap.

Optional Feature:
- Macro: RAM_WRITE_PROTECT_EN.
- Defined:
  - Writes with address < PROTECT_TOP are discarded after init and pulse wire_RAM_ERROR, READ_LATENCY edges after the sample.
  - Reads of the protected region are unaffected.
  - Init still clears the protected region.
- Undefined: PROTECT_TOP is ignored; all in-range writes succeed.

Decomposition:
- Package ram_pkg:
  - RAM_WORD_W = 16.
  - RW_READ = 1'b0, RW_WRITE = 1'b1.
  - ram_state_t enum {ST_INIT, ST_SERVE}.
  - Struct rd_slot_t {valid, data[15:0], err}.
- Sub-module ram_read_pipe:
  - READ_LATENCY-deep shift register of rd_slot_t.
  - Async flush on wire_reset.
  - Output stage holds its last valid data on bubbles.
- Top level holds the array, the FSM, the init counter and the address decode.

Test Plan:
- Reset, DEPTH=16: wire_RAM_READY is 0 for exactly 16 edges after reset release, then 1. Reads of addresses 0..15 all return 16'h0000.
- Write 16'hBEEF to 16'h0005, read 16'h0005 on the next cycle: with READ_LATENCY=2, 16'hBEEF appears two edges after the read sample.
- Back-to-back reads of 3, 4, 5 preloaded with 16'h0A03, 16'h0A04, 16'h0A05: outputs appear on three consecutive cycles in order, with no bubbles.
- DEPTH=16, read address 16'h0020: output 16'h0000 and a one-cycle wire_RAM_ERROR pulse aligned with it. A write to 16'h0020 leaves the array unchanged and pulses error.
- Assert wire_reset while two reads are in flight: output goes to 0 immediately, ready drops, and a full re-init follows. A previously written 16'hBEEF reads back as 16'h0000.
- With RAM_WRITE_PROTECT_EN, PROTECT_TOP=16'h0008, write 16'h1234 to 16'h0003: error pulses and a read returns 16'h0000. Without the macro, the read returns 16'h1234 and there is no error.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and constants for the CPU RAM responder.
package ram_pkg;

  localparam int unsigned RAM_WORD_W = 16;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic {
    ST_INIT,
    ST_SERVE
  } ram_state_t;

  // One slot of the read pipeline; valid=0 marks a bubble (write or idle).
  typedef struct packed {
    logic                  valid;
    logic [RAM_WORD_W-1:0] data;
    logic                  err;
  } rd_slot_t;

endpackage

// File: rtl/ram_read_pipe.sv
// Fixed-latency read return pipeline; the output stage holds its data across bubbles.
module ram_read_pipe
  import ram_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  rd_slot_t              slot_in,
  output logic [RAM_WORD_W-1:0] data_out,
  output logic                  err_out
);

  localparam int unsigned SLOT_W = $bits(rd_slot_t);
  localparam int unsigned PIPE_W = READ_LATENCY * SLOT_W;

  rd_slot_t [READ_LATENCY-1:0] slot_q, slot_d;
  logic [RAM_WORD_W-1:0]       data_q, data_d;
  logic                        err_q, err_d;

  // Shift the pipeline by one slot and update the held output word.
  always_comb begin
    slot_d = PIPE_W'({slot_q, slot_in});
    data_d = data_q;
    err_d  = slot_q[READ_LATENCY-1].err;
    if (slot_q[READ_LATENCY-1].valid) begin
      data_d = slot_q[READ_LATENCY-1].data;
    end
  end

  // Pipeline and output registers; reset flushes everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      slot_q <= slot_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign data_out = data_q;
  assign err_out  = err_q;

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder for the CPU RAM bus: clears the array after reset,
// then serves one read or write per clock with fixed read latency.
// Optional macro RAM_WRITE_PROTECT_EN makes addresses below PROTECT_TOP
// read-only once init has finished.
module ram_responder
  import ram_pkg::*;
#(
  parameter int unsigned           DEPTH        = 4096,
  parameter int unsigned           READ_LATENCY = 1,
  parameter logic [RAM_WORD_W-1:0] INIT_VALUE   = 16'h0000,
  parameter logic [RAM_WORD_W-1:0] PROTECT_TOP  = 16'h0100
) (
  input  logic                  wire_clock,
  input  logic                  wire_reset,
  input  logic [RAM_WORD_W-1:0] bus_RAM_ADDRESS,
  input  logic                  wire_RW,
  input  logic [RAM_WORD_W-1:0] bus_RAM_DATA_IN,
  output logic [RAM_WORD_W-1:0] bus_RAM_DATA_OUT,
  output logic                  wire_RAM_READY,
  output logic                  wire_RAM_ERROR
);

  localparam int unsigned    AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH - 1);

  logic [RAM_WORD_W-1:0] mem_q [DEPTH];

  ram_state_t            state_q, state_d;
  logic [AW-1:0]         init_cnt_q, init_cnt_d;
  logic                  ready_q, ready_d;

  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [RAM_WORD_W-1:0] mem_wdata;
  logic [AW-1:0]         bus_idx;
  logic                  in_range;
  logic                  wr_blocked;
  rd_slot_t              slot_in;

  // Address decode: range check on the full bus, index into the array.
  assign bus_idx  = bus_RAM_ADDRESS[AW-1:0];
  assign in_range = 32'(bus_RAM_ADDRESS) < DEPTH;

`ifdef RAM_WRITE_PROTECT_EN
  assign wr_blocked = bus_RAM_ADDRESS < PROTECT_TOP;
`else
  logic unused_protect_top;
  assign wr_blocked         = 1'b0;
  assign unused_protect_top = ^PROTECT_TOP;
`endif

  // Next state, init sweep, array write port and pipeline entry.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = bus_idx;
    mem_wdata  = bus_RAM_DATA_IN;
    slot_in    = '0;

    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = init_cnt_q;
        mem_wdata = INIT_VALUE;
        if (init_cnt_q == LAST_IDX) begin
          state_d = ST_SERVE;
        end else begin
          init_cnt_d = init_cnt_q + AW'(1);
        end
      end
      ST_SERVE: begin
        if (wire_RW == RW_WRITE) begin
          if (in_range && !wr_blocked) begin
            mem_we = 1'b1;
          end else begin
            slot_in.err = 1'b1;
          end
        end else begin
          slot_in.valid = 1'b1;
          slot_in.err   = !in_range;
          slot_in.data  = in_range ? mem_q[bus_idx] : '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Ready rises on the same edge that completes init.
  always_comb begin
    ready_d = (state_d == ST_SERVE);
  end

  // Control registers.
  always_ff @(posedge wire_clock or posedge wire_reset) begin
    if (wire_reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= ready_d;
    end
  end

  // Single-port word array; contents are defined by the init sweep, not reset.
  always_ff @(posedge wire_clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  ram_read_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_read_pipe (
    .clk     (wire_clock),
    .rst     (wire_reset),
    .slot_in (slot_in),
    .data_out(bus_RAM_DATA_OUT),
    .err_out (wire_RAM_ERROR)
  );

  assign wire_RAM_READY = ready_q;

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder (DEPTH=16, READ_LATENCY=2).
module tb_ram_responder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LAT   = 2;
  localparam logic [15:0] INIT  = 16'h0000;
  localparam logic [15:0] PTOP  = 16'h0008;
`ifdef RAM_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = '0;
  logic        rw = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic        ready;
  logic        err;

  ram_responder #(
    .DEPTH(DEPTH), .READ_LATENCY(LAT), .INIT_VALUE(INIT), .PROTECT_TOP(PTOP)
  ) dut (
    .wire_clock(clk), .wire_reset(rst), .bus_RAM_ADDRESS(addr), .wire_RW(rw),
    .bus_RAM_DATA_IN(din), .bus_RAM_DATA_OUT(dout), .wire_RAM_READY(ready),
    .wire_RAM_ERROR(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents plus a queue of per-access results,
  // each becoming visible LAT edges after it was sampled.
  typedef struct {
    bit          valid;
    logic [15:0] data;
    bit          err;
  } res_t;

  logic [15:0] m_mem [DEPTH];
  res_t        m_q[$];
  logic [15:0] m_dout;
  bit          m_err;

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = INIT;
    m_q.delete();
    m_dout = 16'h0000;
    m_err  = 1'b0;
  endtask

  task automatic model_access(input logic [15:0] a, input logic w, input logic [15:0] d);
    res_t r;
    res_t o;
    r.valid = 1'b0;
    r.data  = 16'h0000;
    r.err   = 1'b0;
    if (int'(a) >= int'(DEPTH)) begin
      r.err   = 1'b1;
      r.valid = !w;
    end else if (w) begin
      if (PROT && a < PTOP) r.err = 1'b1;
      else m_mem[int'(a)] = d;
    end else begin
      r.valid = 1'b1;
      r.data  = m_mem[int'(a)];
    end
    m_q.push_back(r);
    m_err = 1'b0;
    if (m_q.size() > int'(LAT)) begin
      o = m_q.pop_front();
      if (o.valid) m_dout = o.data;
      m_err = o.err;
    end
  endtask

  // One bus access: drive, clock, advance the model; outputs are sampled 1 after the edge.
  task automatic step(input logic [15:0] a, input logic w, input logic [15:0] d);
    addr = a;
    rw   = w;
    din  = d;
    @(posedge clk);
    #1;
    model_access(a, w, d);
  endtask

  // Hold reset, check reset values, release and verify ready timing (exactly DEPTH edges).
  task automatic reset_and_init(input string tag);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk16({tag, "_rst_dout"}, dout, 16'h0000);
    chk1({tag, "_rst_ready"}, ready, 1'b0);
    chk1({tag, "_rst_err"}, err, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= int'(DEPTH); i++) begin
      addr = 16'($urandom_range(0, 15));
      rw   = 1'($urandom_range(0, 1));
      din  = 16'($urandom);
      @(posedge clk);
      #1;
      chk1({tag, "_init_ready"}, ready, (i == int'(DEPTH)));
      chk16({tag, "_init_dout"}, dout, 16'h0000);
    end
    model_reset();
  endtask

  typedef struct {
    logic [15:0] a;
    logic        w;
    logic [15:0] d;
    logic [15:0] xd;
    logic        xe;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] a, input logic w, input logic [15:0] d,
                              input logic [15:0] xd_open, input logic xe_open,
                              input logic [15:0] xd_prot, input logic xe_prot);
    vec_t v;
    v.a  = a;
    v.w  = w;
    v.d  = d;
    v.xd = PROT ? xd_prot : xd_open;
    v.xe = PROT ? xe_prot : xe_open;
    return v;
  endfunction

  vec_t tv [17];

  initial begin
    // Directed table: outputs after each edge reflect the access two edges earlier.
    //          addr      w     data      open:dout  err  prot:dout err
    tv[0]  = mk(16'h0005, 1'b1, 16'hBEEF, 16'h0000, 1'b0, 16'h0000, 1'b0);
    tv[1]  = mk(16'h0005, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    tv[2]  = mk(16'h0003, 1'b1, 16'h0A03, 16'h0000, 1'b0, 16'h0000, 1'b1);
    tv[3]  = mk(16'h0004, 1'b1, 16'h0A04, 16'hBEEF, 1'b0, 16'h0000, 1'b0);
    tv[4]  = mk(16'h0005, 1'b1, 16'h0A05, 16'hBEEF, 1'b0, 16'h0000, 1'b1);
    tv[5]  = mk(16'h0003, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 16'h0000, 1'b1);
    tv[6]  = mk(16'h0004, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 16'h0000, 1'b1);
    tv[7]  = mk(16'h0005, 1'b0, 16'h0000, 16'h0A03, 1'b0, 16'h0000, 1'b0);
    tv[8]  = mk(16'h0020, 1'b0, 16'h0000, 16'h0A04, 1'b0, 16'h0000, 1'b0);
    tv[9]  = mk(16'h0020, 1'b1, 16'h1111, 16'h0A05, 1'b0, 16'h0000, 1'b0);
    tv[10] = mk(16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1);
    tv[11] = mk(16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1);
    tv[12] = mk(16'h0003, 1'b1, 16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b0);
    tv[13] = mk(16'h0003, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    tv[14] = mk(16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
    tv[15] = mk(16'h0000, 1'b0, 16'h0000, 16'h1234, 1'b0, 16'h0000, 1'b0);
    tv[16] = mk(16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

    model_reset();
    reset_and_init("por");

    // Every location reads back as the init value.
    for (int i = 0; i < int'(DEPTH) + int'(LAT); i++) begin
      step(16'(i % int'(DEPTH)), 1'b0, 16'h0000);
      chk16("sweep_dout", dout, m_dout);
      chk1("sweep_err", err, m_err);
    end

    for (int i = 0; i < 17; i++) begin
      step(tv[i].a, tv[i].w, tv[i].d);
      chk16($sformatf("vec%0d_dout", i), dout, tv[i].xd);
      chk1($sformatf("vec%0d_err", i), err, tv[i].xe);
    end

    // Randomized traffic against the model, including out-of-range and top-of-bus addresses.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      a = 16'($urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) a = 16'hFFFF;
      step(a, 1'($urandom_range(0, 1)), 16'($urandom));
      chk16("rand_dout", dout, m_dout);
      chk1("rand_err", err, m_err);
      chk1("rand_ready", ready, 1'b1);
    end

    // Reset with two reads in flight: immediate flush, then full re-init.
    step(16'h000C, 1'b1, 16'hBEEF);
    step(16'h000C, 1'b0, 16'h0000);
    step(16'h000C, 1'b0, 16'h0000);
    step(16'h000C, 1'b0, 16'h0000);
    chk16("pre_rst_dout", dout, 16'hBEEF);
    #2;
    rst = 1'b1;
    #1;
    chk16("midrst_dout", dout, 16'h0000);
    chk1("midrst_ready", ready, 1'b0);
    chk1("midrst_err", err, 1'b0);
    reset_and_init("rerst");
    for (int i = 0; i < int'(LAT) + 1; i++) begin
      step(16'h000C, 1'b0, 16'h0000);
      chk16("reinit_model", dout, m_dout);
    end
    chk16("reinit_beef_cleared", dout, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
